// File: rtl/bpsk_frame_ctrl.sv
// BPSK frame controller: sync-word hunt with phase-ambiguity resolution, payload gating
// into the demapper, 128-bit word capture and a 2-entry valid/ready output FIFO.
module bpsk_frame_ctrl #(
  parameter logic [31:0] SYNC_WORD = 32'h1ACF_FC1D,
  parameter int          SYNC_W    = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         enable,
  input  logic [7:0]   frame_words,
  input  logic         in_valid,
  input  logic [10:0]  in_ar,
  output logic         dm_valid,
  output logic [10:0]  dm_ar,
  input  logic [127:0] dm_word,
  output logic         out_valid,
  output logic [127:0] out_data,
  input  logic         out_ready,
  output logic         frame_done,
  output logic         frame_abort,
  output logic         overflow,
  output logic         inverted,
  output logic [15:0]  frame_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, HUNT = 2'd1, PAYLOAD = 2'd2} state_t;

  localparam logic [31:0] SYNC_MASK = (SYNC_W >= 32) ? 32'hFFFF_FFFF
                                    : 32'((64'd1 << SYNC_W) - 64'd1);
  localparam logic [5:0]  SYNC_W6   = 6'(SYNC_W);

  state_t         state_q, state_d;
  logic [31:0]    shift_q;
  logic [5:0]     fill_q;
  logic [7:0]     words_left_q;
  logic [6:0]     bit_cnt_q;
  logic           inverted_q;
  logic           dm_valid_q;
  logic [10:0]    dm_ar_q;
  logic           c0_q, c0_last_q, c1_q, c1_last_q;
  logic           frame_done_q, frame_abort_q, overflow_q;
  logic [15:0]    frame_cnt_q;
  logic [127:0]   mem_q [2];
  logic           wr_ptr_q, rd_ptr_q;
  logic [1:0]     fifo_cnt_q;

  logic           h_s;
  logic [31:0]    shift_nx_s;
  logic [5:0]     fill_nx_s;
  logic           match_pos_s, match_neg_s;
  logic           hunt_bit_s, lock_s, pay_bit_s, word_end_s, last_word_s;
  logic           flush_s, abort_s, cap_s, pop_s, full_s, push_s, drop_s, done_d;
  logic [10:0]    neg_ar_s, dm_ar_d;

  // Hard decision matches the demapper: zero and negatives decide 0.
  assign h_s         = ~in_ar[10] & (|in_ar[9:0]);
  assign shift_nx_s  = {shift_q[30:0], h_s};
  assign fill_nx_s   = (fill_q >= SYNC_W6) ? fill_q : (fill_q + 6'd1);
  assign match_pos_s = ((shift_nx_s ^ SYNC_WORD) & SYNC_MASK) == 32'd0;
  assign match_neg_s = ((shift_nx_s ^ ~SYNC_WORD) & SYNC_MASK) == 32'd0;
  assign hunt_bit_s  = enable && (state_q == HUNT) && in_valid;
  assign lock_s      = hunt_bit_s && (fill_nx_s >= SYNC_W6) && (match_pos_s || match_neg_s);
  assign pay_bit_s   = enable && (state_q == PAYLOAD) && in_valid;
  assign word_end_s  = pay_bit_s && (bit_cnt_q == 7'd127);
  assign last_word_s = word_end_s && (words_left_q == 8'd1);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = HUNT; else state_d = IDLE;
      HUNT:    if (!enable) state_d = IDLE;
               else if (lock_s && (frame_words != 8'd0)) state_d = PAYLOAD;
               else state_d = HUNT;
      PAYLOAD: if (!enable) state_d = IDLE;
               else if (last_word_s) state_d = HUNT;
               else state_d = PAYLOAD;
      default: state_d = IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    flush_s  = (state_q == IDLE) || !enable;
    abort_s  = (state_q == PAYLOAD) && !enable;
    cap_s    = c1_q && enable;
    pop_s    = (fifo_cnt_q != 2'd0) && out_ready;
    full_s   = (fifo_cnt_q == 2'd2);
    push_s   = cap_s && (!full_s || pop_s);
    drop_s   = cap_s && full_s && !pop_s;
    done_d   = (cap_s && c1_last_q) || (lock_s && (frame_words == 8'd0));
    // Negating -1024 has no 11-bit representation, so it saturates to +1023.
    if (in_ar == 11'h400) begin
      neg_ar_s = 11'h3FF;
    end else begin
      neg_ar_s = ~in_ar + 11'd1;
    end
    if (inverted_q) begin
      dm_ar_d = neg_ar_s;
    end else begin
      dm_ar_d = in_ar;
    end
  end

  // Sync shifter and saturating fill count
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_q <= 32'd0;
      fill_q  <= 6'd0;
    end else if (flush_s || lock_s) begin
      shift_q <= 32'd0;
      fill_q  <= 6'd0;
    end else if (hunt_bit_s) begin
      shift_q <= shift_nx_s;
      fill_q  <= fill_nx_s;
    end
  end

  // Frame bookkeeping: polarity, remaining words, bit position
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inverted_q   <= 1'b0;
      words_left_q <= 8'd0;
      bit_cnt_q    <= 7'd0;
    end else if (flush_s) begin
      inverted_q   <= 1'b0;
      words_left_q <= 8'd0;
      bit_cnt_q    <= 7'd0;
    end else if (lock_s) begin
      inverted_q   <= match_neg_s;
      words_left_q <= frame_words;
      bit_cnt_q    <= 7'd0;
    end else if (pay_bit_s) begin
      bit_cnt_q <= bit_cnt_q + 7'd1;
      if (bit_cnt_q == 7'd127) begin
        words_left_q <= words_left_q - 8'd1;
      end
    end
  end

  // Demapper feed, one cycle after the payload sample
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dm_valid_q <= 1'b0;
      dm_ar_q    <= 11'd0;
    end else begin
      dm_valid_q <= pay_bit_s;
      if (pay_bit_s) begin
        dm_ar_q <= dm_ar_d;
      end
    end
  end

  // Capture pipeline: c1 lines up with the demapper having absorbed bit 127
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      c0_q      <= 1'b0;
      c0_last_q <= 1'b0;
      c1_q      <= 1'b0;
      c1_last_q <= 1'b0;
    end else if (flush_s) begin
      c0_q      <= 1'b0;
      c0_last_q <= 1'b0;
      c1_q      <= 1'b0;
      c1_last_q <= 1'b0;
    end else begin
      c0_q      <= word_end_s;
      c0_last_q <= last_word_s;
      c1_q      <= c0_q;
      c1_last_q <= c0_last_q;
    end
  end

  // Status pulses and frame counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
    end else begin
      frame_done_q  <= done_d;
      frame_abort_q <= abort_s;
      if (done_d) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  // Output FIFO with sticky overflow
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_q[0]   <= 128'd0;
      mem_q[1]   <= 128'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
      overflow_q <= 1'b0;
    end else if (flush_s) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= dm_word;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push_s} - {1'b0, pop_s};
      if (drop_s) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign dm_valid    = dm_valid_q;
  assign dm_ar       = dm_ar_q;
  assign out_valid   = (fifo_cnt_q != 2'd0);
  assign out_data    = mem_q[rd_ptr_q];
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign overflow    = overflow_q;
  assign inverted    = inverted_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
